// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc : multi-cycle datapath ALU with valid/ready handshakes.
//
// Eight operations. Seven of them finish in a single cycle: ADD, SUB, AND,
// NOTB, OR, XOR and SHL. The eighth, MUL, is an iterative shift-add that
// takes WIDTH cycles. The result and the {N,V,Z} status are registered. They
// stay stable while out_valid is high, until the consumer asserts out_ready.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   ALUop/Ain/Bin are valid this cycle
//   in_ready   out  an operation can be accepted this cycle
//   ALUop      in   [2:0] operation select
//   Ain, Bin   in   [WIDTH-1:0] operands
//   out_valid  out  out/status hold a completed result
//   out_ready  in   consumer takes the result this cycle
//   out        out  [WIDTH-1:0] registered result
//   status     out  [2:0] {N,V,Z}
// ---------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUop,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       status
);

    // Number of Bin LSBs used as the shift amount.
    localparam int SHW = $clog2(WIDTH);

    // Count value during the final multiply iteration.
    localparam logic [SHW-1:0] COUNT_LAST = SHW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOTB = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Result of a single-cycle op. MUL is produced by the iterative path, so
    // it yields zero here and is never selected from this function.
    function automatic logic [WIDTH-1:0] alu_result(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_NOTB: r = ~b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SHL:  r = a << b[SHW-1:0];
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // Signed-overflow flag for a single-cycle op. SUB uses the ~Bin form of
    // the ADD rule, because a-b is computed as a + ~b + 1.
    function automatic logic alu_overflow(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] r
    );
        logic v;
        logic [WIDTH-1:0] nb;
        nb = ~b;
        case (op)
            OP_ADD:  v = (a[WIDTH-1] == b[WIDTH-1])  && (r[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:  v = (a[WIDTH-1] == nb[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    // Pack {N,V,Z} from a result and its overflow bit.
    function automatic logic [2:0] make_status(
        input logic [WIDTH-1:0] r,
        input logic             v
    );
        return {r[WIDTH-1], v, (r == {WIDTH{1'b0}})};
    endfunction

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t             state_r;
    logic [WIDTH-1:0]   out_r;
    logic [2:0]         status_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [SHW-1:0]     count_r;

    logic               in_ready_s;
    logic               accept_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_v_s;
    logic [2*WIDTH-1:0] mul_addend_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic               mul_last_s;
    logic [2:0]         mul_status_s;

    // Handshake. In DONE, ready follows out_ready so that the consumer taking
    // a result and a new accept can happen on the same edge.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
            ST_DONE: in_ready_s = out_ready;
            default: in_ready_s = 1'b0;
        endcase
        accept_s = in_valid & in_ready_s;
    end

    // Single-cycle result and flags, computed straight from the ports.
    always_comb begin
        alu_res_s = alu_result(ALUop, Ain, Bin);
        alu_v_s   = alu_overflow(ALUop, Ain, Bin, alu_res_s);
    end

    // One shift-add step. The multiplicand is placed at bit position count_r
    // rather than shifted in place, which keeps mcand_r constant for the
    // whole operation.
    always_comb begin
        if (mplier_r[0]) begin
            mul_addend_s = {{WIDTH{1'b0}}, mcand_r} << count_r;
        end else begin
            mul_addend_s = {(2*WIDTH){1'b0}};
        end
        acc_next_s   = acc_r + mul_addend_s;
        mul_last_s   = (count_r == COUNT_LAST);
        // V for MUL reports that the upper half of the full product is nonzero.
        mul_status_s = make_status(acc_next_s[WIDTH-1:0],
                                   (acc_next_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}}));
    end

    // Controller FSM and result/status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_r       <= {WIDTH{1'b0}};
            status_r    <= 3'b000;
            out_valid_r <= 1'b0;
            mcand_r     <= {WIDTH{1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
            count_r     <= {SHW{1'b0}};
        end else if (accept_s) begin
            // An accept can only happen from IDLE, or from DONE while the
            // consumer is taking the result. Both cases start the new op.
            if (ALUop == OP_MUL) begin
                mcand_r     <= Ain;
                mplier_r    <= Bin;
                acc_r       <= {(2*WIDTH){1'b0}};
                count_r     <= {SHW{1'b0}};
                out_valid_r <= 1'b0;
                state_r     <= ST_MUL;
            end else begin
                out_r       <= alu_res_s;
                status_r    <= make_status(alu_res_s, alu_v_s);
                out_valid_r <= 1'b1;
                state_r     <= ST_DONE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_MUL: begin
                    acc_r    <= acc_next_s;
                    mplier_r <= mplier_r >> 1;
                    count_r  <= count_r + SHW'(1);
                    // A zero multiplier still runs every iteration; there is
                    // no early exit.
                    if (mul_last_s) begin
                        out_r       <= acc_next_s[WIDTH-1:0];
                        status_r    <= mul_status_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        state_r     <= ST_MUL;
                    end
                end
                ST_DONE: begin
                    // out/status keep their value after the result is
                    // consumed; only out_valid drops.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign status    = status_r;

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc : self-checking bench for alu_mc (WIDTH=16). Directed cases come
// from the worked examples. Randomized cases are compared against a
// reference model written with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_mc;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2:0]     ALUop = 3'b000;
    logic [W-1:0]   Ain = 16'h0000;
    logic [W-1:0]   Bin = 16'h0000;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out;
    logic [2:0]     status;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUop     (ALUop),
        .Ain       (Ain),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .status    (status)
    );

    always #5 clk = ~clk;

    // Reference model, using signed/unsigned integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [2:0] st);
        longint ua, ub, sa, sb, full;
        logic v;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        v  = 1'b0;
        full = 0;
        case (op)
            3'd0: begin full = sa + sb; v = (full > 32767) || (full < -32768); end
            3'd1: begin full = sa - sb; v = (full > 32767) || (full < -32768); end
            3'd2: full = ua & ub;
            3'd3: full = ~ub;
            3'd4: full = ua | ub;
            3'd5: full = ua ^ ub;
            3'd6: full = ua << (ub % 16);
            default: begin full = ua * ub; v = ((full >> 16) != 0); end
        endcase
        r  = full[W-1:0];
        st = {r[W-1], v, (r == 16'h0000)};
    endfunction

    // Move to 1 time unit after the next rising edge, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one op, wait for it to be accepted, then wait for out_valid.
    // lat counts edges from the accept edge (inclusive) to out_valid.
    // busy counts the samples taken while waiting in which in_ready was high.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [2:0] st,
                         output int lat, output int busy);
        int guard;
        guard = 0;
        ALUop = op; Ain = a; Bin = b; in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        step();
        in_valid = 1'b0;
        ALUop = 3'($urandom);
        Ain   = 16'($urandom);
        Bin   = 16'($urandom);
        lat  = 1;
        busy = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy++;
            step();
            lat++;
        end
        r  = out;
        st = status;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (out !== 16'h0000 || status !== 3'b000 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values out=%h status=%b out_valid=%b expected 0000/000/0",
                     out, status, out_valid);
        end
        step();
        step();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got=%b expected=1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] r;
        logic [2:0]   st;
        int lat, busy;
        out_ready = 1'b1;
        do_op(3'b000, 16'h7FFF, 16'h0001, r, st, lat, busy);
        n_checks++;
        if (r !== 16'h8000 || st !== 3'b110 || lat !== 1) begin
            n_fail++;
            $display("FAIL add_ovf out=%h status=%b lat=%0d expected 8000/110/1", r, st, lat);
        end
        do_op(3'b001, 16'h0005, 16'h0005, r, st, lat, busy);
        n_checks++;
        if (r !== 16'h0000 || st !== 3'b001) begin
            n_fail++;
            $display("FAIL sub_zero out=%h status=%b expected 0000/001", r, st);
        end
        do_op(3'b001, 16'h8000, 16'h0001, r, st, lat, busy);
        n_checks++;
        if (r !== 16'h7FFF || st !== 3'b010) begin
            n_fail++;
            $display("FAIL sub_ovf out=%h status=%b expected 7fff/010", r, st);
        end
        do_op(3'b110, 16'h0001, 16'h0013, r, st, lat, busy);
        n_checks++;
        if (r !== 16'h0008 || st !== 3'b000) begin
            n_fail++;
            $display("FAIL shl out=%h status=%b expected 0008/000", r, st);
        end
        do_op(3'b011, 16'h1234, 16'h00FF, r, st, lat, busy);
        n_checks++;
        if (r !== 16'hFF00 || st !== 3'b100) begin
            n_fail++;
            $display("FAIL notb out=%h status=%b expected ff00/100", r, st);
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] r;
        logic [2:0]   st;
        int lat, busy;
        out_ready = 1'b1;
        do_op(3'b111, 16'h0100, 16'h0100, r, st, lat, busy);
        n_checks++;
        if (r !== 16'h0000 || st !== 3'b011 || lat !== W + 1 || busy !== 0) begin
            n_fail++;
            $display("FAIL mul_ovf out=%h status=%b lat=%0d busy=%0d expected 0000/011/17/0",
                     r, st, lat, busy);
        end
        do_op(3'b111, 16'h0003, 16'h0005, r, st, lat, busy);
        n_checks++;
        if (r !== 16'h000F || st !== 3'b000 || lat !== W + 1) begin
            n_fail++;
            $display("FAIL mul_small out=%h status=%b lat=%0d expected 000f/000/17", r, st, lat);
        end
        do_op(3'b111, 16'h0000, 16'hFFFF, r, st, lat, busy);
        n_checks++;
        if (r !== 16'h0000 || st !== 3'b001 || lat !== W + 1) begin
            n_fail++;
            $display("FAIL mul_zero out=%h status=%b lat=%0d expected 0000/001/17", r, st, lat);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] r, er, a, b;
        logic [2:0]   st, est, op;
        int lat, busy, elat;
        logic [W-1:0] corner [4];
        corner[0] = 16'h0000; corner[1] = 16'hFFFF;
        corner[2] = 16'h8000; corner[3] = 16'h7FFF;
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom);
            a  = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(3, 0)] : 16'($urandom);
            b  = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(3, 0)] : 16'($urandom);
            model(op, a, b, er, est);
            elat = (op == 3'b111) ? W + 1 : 1;
            do_op(op, a, b, r, st, lat, busy);
            n_checks++;
            if (r !== er || st !== est || lat !== elat || busy !== 0) begin
                n_fail++;
                $display("FAIL random op=%b a=%h b=%h got out=%h status=%b lat=%0d busy=%0d expected %h/%b/%0d/0",
                         op, a, b, r, st, lat, busy, er, est, elat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] er, a, b;
        logic [2:0]   est;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            model(3'b000, a, b, er, est);
            ALUop = 3'b000; Ain = a; Bin = b; in_valid = 1'b1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready idx=%0d got=%b expected=1", i, in_ready);
            end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out !== er || status !== est) begin
                n_fail++;
                $display("FAIL b2b_result idx=%0d got %b/%h/%b expected 1/%h/%b",
                         i, out_valid, out, status, er, est);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] r, er;
        logic [2:0]   st, est;
        int lat, busy;
        model(3'b000, 16'h1234, 16'h1111, er, est);
        out_ready = 1'b0;
        do_op(3'b000, 16'h1234, 16'h1111, r, st, lat, busy);
        n_checks++;
        if (r !== er || st !== est) begin
            n_fail++;
            $display("FAIL bp_add out=%h status=%b expected %h/%b", r, st, er, est);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (out !== er || status !== est || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d got %h/%b/%b/%b expected %h/%b/1/0",
                         i, out, status, out_valid, in_ready, er, est);
            end
        end
        ALUop = 3'b010; Ain = 16'hF0F0; Bin = 16'h0FF0; in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready got=%b expected=1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out !== 16'h00F0 || status !== 3'b000) begin
            n_fail++;
            $display("FAIL bp_and got %b/%h/%b expected 1/00f0/000", out_valid, out, status);
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        logic [W-1:0] r;
        logic [2:0]   st;
        int lat, busy, stray;
        out_ready = 1'b1;
        ALUop = 3'b111; Ain = 16'h0100; Bin = 16'h0100; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midmul_busy got=%b expected=0", in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out !== 16'h0000 || status !== 3'b000 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midmul_reset got %h/%b/%b expected 0000/000/0", out, status, out_valid);
        end
        #2;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midmul_ready got=%b expected=1", in_ready);
        end
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) stray++;
            step();
        end
        n_checks++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL midmul_stray got=%0d valid cycles expected=0", stray);
        end
        do_op(3'b000, 16'h0002, 16'h0003, r, st, lat, busy);
        n_checks++;
        if (r !== 16'h0005 || st !== 3'b000 || lat !== 1) begin
            n_fail++;
            $display("FAIL midmul_add out=%h status=%b lat=%0d expected 0005/000/1", r, st, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
